// File: rtl/umi_reghost.sv
// Register-to-UMI host bridge: one register read/write becomes one UMI request, then waits for its response.
// Build option: define UMI_REGHOST_TIMEOUT_EN to give up on a missing response after TOCYCLES cycles.
module umi_reghost #(
    parameter int              AW       = 64,
    parameter int              CW       = 32,
    parameter int              DW       = 256,
    parameter int              RW       = 64,
    parameter logic [AW-1:0]   HOSTADDR = '0,
    parameter int              TOCYCLES = 1024
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          reg_read,
    input  logic          reg_write,
    input  logic          reg_posted,
    input  logic [AW-1:0] reg_addr,
    input  logic [2:0]    reg_size,
    input  logic [RW-1:0] reg_wrdata,
    output logic          reg_ready,
    output logic          reg_done,
    output logic [RW-1:0] reg_rddata,
    output logic [1:0]    reg_err,
    output logic          uhost_req_valid,
    output logic [CW-1:0] uhost_req_cmd,
    output logic [AW-1:0] uhost_req_dstaddr,
    output logic [AW-1:0] uhost_req_srcaddr,
    output logic [DW-1:0] uhost_req_data,
    input  logic          uhost_req_ready,
    input  logic          uhost_resp_valid,
    input  logic [CW-1:0] uhost_resp_cmd,
    input  logic [AW-1:0] uhost_resp_dstaddr,
    input  logic [AW-1:0] uhost_resp_srcaddr,
    input  logic [DW-1:0] uhost_resp_data,
    output logic          uhost_resp_ready
);

    localparam logic [4:0] UMI_REQ_READ   = 5'b00001;
    localparam logic [4:0] UMI_REQ_WRITE  = 5'b00011;
    localparam logic [4:0] UMI_REQ_POSTED = 5'b00101;
    localparam logic [4:0] UMI_RESP_READ  = 5'b00010;
    localparam logic [4:0] UMI_RESP_WRITE = 5'b00100;

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

    state_t        state_q, state_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic [1:0]    err_q, err_d;
    logic [RW-1:0] rddata_q, rddata_d;
    logic [CW-1:0] cmd_q, cmd_d;
    logic [AW-1:0] dstaddr_q, dstaddr_d;
    logic [AW-1:0] srcaddr_q, srcaddr_d;
    logic [RW-1:0] wrdata_q, wrdata_d;
    logic          is_read_q, is_read_d;
    logic          posted_q, posted_d;

    logic          resp_timeout;
    logic [4:0]    resp_opcode;
    logic [1:0]    resp_err;
    logic [4:0]    expect_opcode;

    // Response err lives in the user field of a UMI response command.
    assign resp_opcode   = uhost_resp_cmd[4:0];
    assign resp_err      = uhost_resp_cmd[26:25];
    assign expect_opcode = is_read_q ? UMI_RESP_READ : UMI_RESP_WRITE;

`ifdef UMI_REGHOST_TIMEOUT_EN
    localparam int CNTW = (TOCYCLES > 2) ? $clog2(TOCYCLES) : 1;

    logic [CNTW-1:0] tocnt_q, tocnt_d;

    assign resp_timeout = (tocnt_q == CNTW'(TOCYCLES - 1));

    always_comb begin
        tocnt_d = tocnt_q;
        if (state_q == REQ && uhost_req_ready && !posted_q) begin
            tocnt_d = '0;
        end else if (state_q == RESP && !uhost_resp_valid && !resp_timeout) begin
            tocnt_d = tocnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            tocnt_q <= '0;
        end else begin
            tocnt_q <= tocnt_d;
        end
    end
`else
    logic unused_tocycles;
    assign unused_tocycles = ^TOCYCLES;
    assign resp_timeout    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        err_d     = err_q;
        rddata_d  = rddata_q;
        cmd_d     = cmd_q;
        dstaddr_d = dstaddr_q;
        srcaddr_d = srcaddr_q;
        wrdata_d  = wrdata_q;
        is_read_d = is_read_q;
        posted_d  = posted_q;

        case (state_q)
            IDLE: begin
                if (ready_q && (reg_read || reg_write)) begin
                    // A simultaneous write is dropped in favour of the read.
                    is_read_d  = reg_read;
                    posted_d   = !reg_read && reg_posted;
                    cmd_d      = '0;
                    cmd_d[4:0] = reg_read ? UMI_REQ_READ :
                                 (reg_posted ? UMI_REQ_POSTED : UMI_REQ_WRITE);
                    cmd_d[7:5] = reg_size;
                    cmd_d[22]  = 1'b1;
                    dstaddr_d  = reg_addr;
                    srcaddr_d  = HOSTADDR;
                    wrdata_d   = reg_wrdata;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (uhost_req_ready) begin
                    if (posted_q) begin
                        done_d  = 1'b1;
                        err_d   = 2'b00;
                        state_d = IDLE;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (uhost_resp_valid) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                    if (resp_opcode == expect_opcode) begin
                        err_d = resp_err;
                        if (is_read_q) begin
                            rddata_d = uhost_resp_data[RW-1:0];
                        end
                    end else begin
                        err_d = 2'b10;
                    end
                end else if (resp_timeout) begin
                    done_d  = 1'b1;
                    err_d   = 2'b11;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= '0;
            rddata_q  <= '0;
            cmd_q     <= '0;
            dstaddr_q <= '0;
            srcaddr_q <= '0;
            wrdata_q  <= '0;
            is_read_q <= 1'b0;
            posted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rddata_q  <= rddata_d;
            cmd_q     <= cmd_d;
            dstaddr_q <= dstaddr_d;
            srcaddr_q <= srcaddr_d;
            wrdata_q  <= wrdata_d;
            is_read_q <= is_read_d;
            posted_q  <= posted_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DW / RW; gi++) begin : g_rep
            assign uhost_req_data[gi*RW +: RW] = wrdata_q;
        end
        if ((DW % RW) != 0) begin : g_pad
            assign uhost_req_data[DW-1:(DW/RW)*RW] = '0;
        end
    endgenerate

    logic unused_resp;
    assign unused_resp = ^{uhost_resp_dstaddr, uhost_resp_srcaddr, uhost_resp_data, uhost_resp_cmd};

    assign reg_ready         = ready_q;
    assign reg_done          = done_q;
    assign reg_err           = err_q;
    assign reg_rddata        = rddata_q;
    assign uhost_req_valid   = (state_q == REQ);
    assign uhost_req_cmd     = cmd_q;
    assign uhost_req_dstaddr = dstaddr_q;
    assign uhost_req_srcaddr = srcaddr_q;
    assign uhost_resp_ready  = (state_q == RESP);

endmodule
